burst_memory: RTL and testbench
===============================

// Module: burst_memory
// PURPOSE
//  Parametrised 2^M x N-bit register memory with burst access. One Start
//  request transfers 1..2^L consecutive words, with the address auto-incrementing
//  and wrapping modulo 2^M.
//  It replaces the single-cell, tri-state, one-word-per-clock memory. It uses
//  separate registered read and write data paths with valid/busy/done handshakes.
//  It sits between the controller/sequencer and the datapath as scratch storage.
// PARAMETERS
//  N  8  word width (bits)
//  M  4  address width; depth = 2**M cells
//  L  2  burst-length field width; max burst = 2**L words
// PORTS
//  Clock    in   1  posedge clock (the only clock)
//  ResetN   in   1  asynchronous, active-low reset
//  Start    in   1  burst request; sampled in IDLE only
//  RW       in   1  0=read burst, 1=write burst; sampled with Start
//  Address  in   M  first cell of the burst; sampled with Start
//  Length   in   L  burst beats minus one (0 => 1 word); sampled with Start
//  WData    in   N  write data for the current beat
//  WValid   in   1  WData valid this cycle (write bursts only)
//  RData    out  N  registered read data
//  RValid   out  1  RData valid this cycle
//  Busy     out  1  high whenever state != IDLE
//  Done     out  1  one-cycle pulse at the end of a burst
// BEHAVIOUR
//  Reset (ResetN=0, takes effect immediately, async):
//   - every cell = 0; state = IDLE; ptr = 0; cnt = 0.
//   - RData = 0; RValid = 0; Busy = 0; Done = 0.
//   - Reset during a burst aborts it. No Done is issued.
//  FSM states: IDLE, READ, WRITE, DONE. All outputs are registered.
//  IDLE:
//   - On an edge with Start=1: latch ptr<=Address, cnt<=Length.
//   - Go to READ if RW=0, else WRITE. The other inputs are ignored.
//  READ:
//   - Every edge is one beat: RData<=mem[ptr], RValid<=1, ptr<=ptr+1 (wraps 2^M-1 -> 0).
//   - If cnt==0, go to DONE; otherwise cnt<=cnt-1.
//   - Latency: Start sampled at edge t gives the first RValid cycle after edge t+1.
//   - Beats are back-to-back, with no stall input.
//  WRITE:
//   - On an edge with WValid=1: mem[ptr]<=WData, ptr++ (wraps).
//   - If cnt==0, go to DONE; otherwise cnt--.
//   - WValid=0 stalls the burst; state, ptr and cnt hold.
//  DONE:
//   - Done=1 for exactly one cycle, then IDLE.
//   - After a read burst, RValid/RData hold the last beat in this cycle, so the
//     last RValid coincides with Done.
//  Outside the beat cycles RValid=0 and RData holds its last value.
//  Busy=1 in READ, WRITE and DONE. Start is ignored while Busy=1, including in DONE.
//   - A new burst can therefore be sampled no earlier than the first IDLE edge.
//  WValid is ignored outside WRITE. Memory contents change only on WRITE beats.
//  A write beat is readable by any later read burst. Read and write never overlap.
//  Length=2^L-1 with wrap: the burst continues 2^M-1 -> 0 with no error or flag.
// TESTING
//  T1 Reset values: ResetN=0 -> all outputs 0; after release, a read of every
//     cell returns 0.
//  T2 Write burst: Start, RW=1, Address=3, Length=3, WData 0xA1..0xA4 with
//     WValid each cycle -> cells 3..6 written; Done pulses 1 cycle after the
//     4th beat; Busy high for 5 cycles.
//  T3 Read burst: read Addr=3, Len=3 -> RValid for 4 consecutive cycles with
//     RData 0xA1,0xA2,0xA3,0xA4; the first is 2 edges after Start; Done
//     coincides with 0xA4.
//  T4 Wrap and stall (M=4): write Addr=14, Len=3, with WValid low for 2 cycles
//     mid-burst -> cells 14,15,0,1 written, nothing else changes, Busy stays
//     high through the stall.
//  T5 Start while Busy: pulse Start (RW=1, Address=0) during the T3 read ->
//     ignored; cell 0 unchanged; the read completes normally.
//  T6 Reset mid-burst: assert ResetN=0 after beat 2 of a write -> immediate
//     IDLE, no Done, outputs 0; a later read of the whole range returns 0.

Source files
------------

// File: rtl/burst_memory.sv
// Register-file scratch memory with burst read/write access.
// A single request moves 1..2^L consecutive words; the address wraps modulo 2^M.
module burst_memory #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int L = 2
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         Start,
  input  logic         RW,
  input  logic [M-1:0] Address,
  input  logic [L-1:0] Length,
  input  logic [N-1:0] WData,
  input  logic         WValid,
  output logic [N-1:0] RData,
  output logic         RValid,
  output logic         Busy,
  output logic         Done
);

  localparam int DEPTH = 1 << M;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t       state;
  logic [M-1:0] ptr;
  logic [L-1:0] cnt;
  logic [N-1:0] mem [DEPTH];

  // Burst sequencer and storage share one process so every output stays registered.
  // RValid and Done default low, so each is only high for the cycle after the edge that set it.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      RData  <= '0;
      RValid <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      RValid <= 1'b0;
      Done   <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            ptr   <= Address;
            cnt   <= Length;
            Busy  <= 1'b1;
            state <= RW ? WRITE : READ;
          end
        end
        READ: begin
          RData  <= mem[ptr];
          RValid <= 1'b1;
          ptr    <= ptr + 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            Done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          // A cycle without WValid is a stall: pointer and count hold.
          if (WValid) begin
            mem[ptr] <= WData;
            ptr      <= ptr + 1'b1;
            if (cnt == '0) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_memory.sv
// Directed and randomized bursts against a behavioural memory model.
// Expected read data and handshake timing come from the model's address arithmetic.
module tb_burst_memory;

  localparam int N = 8;
  localparam int M = 4;
  localparam int L = 2;
  localparam int DEPTH = 1 << M;

  logic         Clock   = 1'b0;
  logic         ResetN  = 1'b1;
  logic         Start   = 1'b0;
  logic         RW      = 1'b0;
  logic [M-1:0] Address = '0;
  logic [L-1:0] Length  = '0;
  logic [N-1:0] WData   = '0;
  logic         WValid  = 1'b0;
  logic [N-1:0] RData;
  logic         RValid;
  logic         Busy;
  logic         Done;

  logic [N-1:0] refMem [DEPTH];
  int passCount   = 0;
  int failCount   = 0;
  int totalChecks = 0;

  burst_memory #(.N(N), .M(M), .L(L)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Start  (Start),
    .RW     (RW),
    .Address(Address),
    .Length (Length),
    .WData  (WData),
    .WValid (WValid),
    .RData  (RData),
    .RValid (RValid),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled and inputs changed 1ns after each rising edge.
  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic rw, input int addr, input int len,
                               input logic wvalid, input int wdata);
    Start   = start;
    RW      = rw;
    Address = addr[M-1:0];
    Length  = len[L-1:0];
    WValid  = wvalid;
    WData   = wdata[N-1:0];
  endtask

  task automatic clearModel;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
  endtask

  task automatic readBurst(input int addr, input int len, input bit busyStart, input string tag);
    int a;
    applyStimulus(1'b1, 1'b0, addr, len, 1'b0, 0);
    step;
    if (busyStart) applyStimulus(1'b1, 1'b1, 0, 3, 1'b1, 'h5A);
    else           applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
    checkOutput($sformatf("%s.lat.Busy", tag), Busy, 1);
    checkOutput($sformatf("%s.lat.RValid", tag), RValid, 0);
    checkOutput($sformatf("%s.lat.Done", tag), Done, 0);
    for (int k = 0; k <= len; k++) begin
      step;
      a = (addr + k) % DEPTH;
      checkOutput($sformatf("%s.beat%0d.RValid", tag, k), RValid, 1);
      checkOutput($sformatf("%s.beat%0d.RData@%0d", tag, k, a), RData, refMem[a]);
      checkOutput($sformatf("%s.beat%0d.Done", tag, k), Done, (k == len) ? 1 : 0);
      checkOutput($sformatf("%s.beat%0d.Busy", tag, k), Busy, 1);
    end
    step;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
    checkOutput($sformatf("%s.end.Busy", tag), Busy, 0);
    checkOutput($sformatf("%s.end.RValid", tag), RValid, 0);
    checkOutput($sformatf("%s.end.Done", tag), Done, 0);
    checkOutput($sformatf("%s.end.RDataHold", tag), RData, refMem[(addr + len) % DEPTH]);
    step;
    checkOutput($sformatf("%s.idle.Busy", tag), Busy, 0);
  endtask

  task automatic writeBurst(input int addr, input int len, input int dataBase,
                            input int stallAt, input int stallCycles, input string tag);
    int d;
    applyStimulus(1'b1, 1'b1, addr, len, 1'b1, 'hEE);
    step;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
    checkOutput($sformatf("%s.start.Busy", tag), Busy, 1);
    checkOutput($sformatf("%s.start.Done", tag), Done, 0);
    for (int k = 0; k <= len; k++) begin
      if (k == stallAt) begin
        for (int s = 0; s < stallCycles; s++) begin
          applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, $urandom_range(0, 255));
          step;
          checkOutput($sformatf("%s.stall%0d.Busy", tag, s), Busy, 1);
          checkOutput($sformatf("%s.stall%0d.Done", tag, s), Done, 0);
        end
      end
      d = (dataBase < 0) ? $urandom_range(0, 255) : dataBase + k;
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, d);
      step;
      refMem[(addr + k) % DEPTH] = d[N-1:0];
      checkOutput($sformatf("%s.beat%0d.Done", tag, k), Done, (k == len) ? 1 : 0);
      checkOutput($sformatf("%s.beat%0d.Busy", tag, k), Busy, 1);
      checkOutput($sformatf("%s.beat%0d.RValid", tag, k), RValid, 0);
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
    step;
    checkOutput($sformatf("%s.end.Busy", tag), Busy, 0);
    checkOutput($sformatf("%s.end.Done", tag), Done, 0);
  endtask

  task automatic readAll(input string tag);
    for (int base = 0; base < DEPTH; base += 4) begin
      readBurst(base, 3, 1'b0, $sformatf("%s.rd%0d", tag, base));
    end
  endtask

  initial begin
    int rw;
    int addr;
    int len;
    clearModel();

    // Asynchronous reset with no clock edge involved.
    #2 ResetN = 1'b0;
    #1;
    checkOutput("T1.rst.RData", RData, 0);
    checkOutput("T1.rst.RValid", RValid, 0);
    checkOutput("T1.rst.Busy", Busy, 0);
    checkOutput("T1.rst.Done", Done, 0);
    step;
    step;
    ResetN = 1'b1;
    step;
    readAll("T1");

    writeBurst(3, 3, 'hA1, -1, 0, "T2");
    readBurst(3, 3, 1'b1, "T3T5");
    writeBurst(14, 3, 'hB1, 2, 2, "T4");
    readAll("T4chk");

    for (int i = 0; i < 24; i++) begin
      rw   = $urandom_range(0, 1);
      addr = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(0, (1 << L) - 1);
      if (rw == 1) writeBurst(addr, len, -1, $urandom_range(0, 4), $urandom_range(1, 2), $sformatf("RND%0d.W", i));
      else         readBurst(addr, len, $urandom_range(0, 1) == 1, $sformatf("RND%0d.R", i));
    end

    // Abort a write burst after its second beat.
    applyStimulus(1'b1, 1'b1, 5, 3, 1'b0, 0);
    step;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 'h77);
    step;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 'h78);
    step;
    checkOutput("T6.pre.Busy", Busy, 1);
    ResetN = 1'b0;
    #1;
    clearModel();
    checkOutput("T6.rst.Busy", Busy, 0);
    checkOutput("T6.rst.Done", Done, 0);
    checkOutput("T6.rst.RValid", RValid, 0);
    checkOutput("T6.rst.RData", RData, 0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0);
    step;
    checkOutput("T6.hold.Done", Done, 0);
    ResetN = 1'b1;
    step;
    checkOutput("T6.idle.Busy", Busy, 0);
    readAll("T6");

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
